pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/stall controller for the four-stage pipeline (IF, ID, EX, WB).
//  Drives the PC write enable, the IF_ID write/flush controls, the ID->EX bubble and the EX hold.
//  Handles taken-branch flush, load-use interlock, multi-cycle MUL occupancy, imem wait and halt drain.
//  Also keeps stall and flush performance counters.
// PARAMETERS
//  REG_AW   5   register-address width (rs/rd fields)
//  MUL_LAT  3   EX occupancy of a MUL in cycles; legal range >=2
//  CNT_W    16  width of the perf counters
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       asynchronous, active-low reset
//  id_rs1,id_rs2    in   REG_AW  source regs of the instruction in ID (IF_ID output)
//  id_rs1_used      in   1       rs1 is read by the ID instruction
//  id_rs2_used      in   1       rs2 is read by the ID instruction
//  ex_valid         in   1       EX holds a real (non-bubble) instruction
//  ex_rd            in   REG_AW  destination reg of the EX instruction
//  ex_is_load       in   1       EX instruction is a load (data ready only in WB)
//  ex_is_mul        in   1       EX instruction is a multi-cycle MUL
//  ex_branch_taken  in   1       EX resolved a taken branch/jump this cycle
//  imem_ready       in   1       instruction memory returns valid data this cycle
//  halt_req         in   1       request to stop fetching and drain
//  pc_we            out  1       PC update enable
//  if_id_we         out  1       IF_ID load enable (0 = hold)
//  if_id_flush      out  1       IF_ID loads a NOP
//  id_ex_bubble     out  1       ID/EX loads a bubble
//  ex_hold          out  1       EX stage keeps its current instruction
//  halted           out  1       registered; 1 in HALT
//  state_o          out  2       current FSM state
//  stall_cnt        out  CNT_W   cycles with pc_we=0 outside HALT; saturating
//  flush_cnt        out  CNT_W   taken-branch flushes; saturating
// BEHAVIOUR
//  - Control outputs are combinational from state and inputs, so they act in the cycle the hazard is seen.
//  - State, mul counter, halt_pend and perf counters are registered.
//  - Reset (rst=0): state=RUN, mul cnt=0, halt_pend=0, counters=0, halted=0.
//    Outputs are forced to pc_we=0, if_id_we=1, if_id_flush=1, id_ex_bubble=1, ex_hold=0.
//  - States: RUN=0, MUL_WAIT=1, DRAIN=2, HALT=3.
//  - Default in RUN: pc_we=1, if_id_we=1, all others 0.
//  - RUN priority, highest first:
//    1. ex_branch_taken: pc_we=1, if_id_flush=1, id_ex_bubble=1; flush_cnt+1.
//    2. ex_valid&ex_is_mul: pc_we=0, if_id_we=0, ex_hold=1; cnt<=MUL_LAT-2; go to MUL_WAIT.
//    3. load-use: ex_valid&ex_is_load&ex_rd!=0 and the rd matches a used rs.
//       Response: pc_we=0, if_id_we=0, id_ex_bubble=1 for exactly one cycle; stay in RUN.
//    4. halt_req|halt_pend: pc_we=0, if_id_flush=1; cnt<=1; go to DRAIN.
//    5. !imem_ready: pc_we=0, if_id_flush=1 (bubble into IF_ID).
//  - MUL_WAIT, cnt!=0: pc_we=0, if_id_we=0, ex_hold=1; cnt-1.
//    MUL_WAIT, cnt==0: release, ex_hold=0, RUN defaults apply; next state is RUN.
//    Total ex_hold cycles = MUL_LAT-1.
//  - halt_req outside RUN sets halt_pend, which is serviced on return to RUN.
//  - DRAIN: pc_we=0, if_id_flush=1 for 2 cycles, then HALT.
//  - HALT: pc_we=0, if_id_flush=1, halted=1. Left only by reset.
//  - ex_branch_taken&ex_is_mul is illegal; the bench asserts on it.
//  - stall_cnt and flush_cnt saturate at all-ones and do not wrap.
//  - Reset mid-MUL_WAIT or mid-DRAIN returns to RUN immediately; no pending state survives.
// STRUCTURE
//  - define.v gains `REG_AW and the state encodings `HZ_RUN/`HZ_MUL/`HZ_DRAIN/`HZ_HALT.
//  - One sub-module: lu_hazard_detect, the combinational load-use rs/rd compare.
//  - FSM, counters and output decode stay in this module.
// TESTING
//  1 Load r3 in EX, ID reads rs1=3 -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cnt=1.
//  2 Load r0 in EX, ID reads r0 -> no stall.
//  3 MUL in EX, MUL_LAT=3 -> ex_hold=1 for 2 cycles, then RUN; stall_cnt=2.
//  4 Taken branch with a load-use hazard in the same cycle -> flush wins: if_id_flush=1, pc_we=1, flush_cnt=1.
//  5 halt_req during MUL_WAIT -> MUL completes, then DRAIN 2 cycles, then halted=1 and pc_we stays 0.
//  6 rst low mid-MUL_WAIT -> state_o=0, counters 0, forced reset outputs at once, independent of clk.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: state encoding and default widths for the hazard controller
package pipe_hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } hz_state_t;
    localparam int REG_AW_D  = 5;
    localparam int MUL_LAT_D = 3;
    localparam int CNT_W_D   = 16;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stall/flush controls and perf counters out
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_D,
    parameter int CNT_W  = CNT_W_D
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic              ex_is_mul;
    logic              ex_branch_taken;
    logic              imem_ready;
    logic              halt_req;
    logic              pc_we;
    logic              if_id_we;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              ex_hold;
    logic              halted;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid, ex_rd, ex_is_load,
               ex_is_mul, ex_branch_taken, imem_ready, halt_req,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold, halted, state_o,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid, ex_rd, ex_is_load,
               ex_is_mul, ex_branch_taken, imem_ready, halt_req,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold, halted, state_o,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_lu_hazard_detect.sv
// lu_hazard_detect: flags an ID source read of a register a load in EX has not produced yet
module lu_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_D
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    output logic              hazard
);
    // r0 is hardwired zero, so a load into it never creates a dependency
    assign hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush FSM for the IF/ID/EX/WB pipeline with saturating perf counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_D,
    parameter int MUL_LAT = MUL_LAT_D,
    parameter int CNT_W   = CNT_W_D
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CW = $clog2(MUL_LAT);
    hz_state_t        state, nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             halt_pend, halted, lu;
    logic             pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold, inc_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    lu_hazard_detect #(.REG_AW(REG_AW)) u_lu (
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_rs1_used (hz.id_rs1_used),
        .id_rs2_used (hz.id_rs2_used),
        .ex_valid    (hz.ex_valid),
        .ex_rd       (hz.ex_rd),
        .ex_is_load  (hz.ex_is_load),
        .hazard      (lu)
    );

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        inc_flush    = 1'b0;
        nxt          = state;
        cnt_nxt      = cnt;
        if (!rst) begin
            pc_we        = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        inc_flush    = 1'b1;
                    end else if (hz.ex_valid && hz.ex_is_mul) begin
                        pc_we    = 1'b0;
                        if_id_we = 1'b0;
                        ex_hold  = 1'b1;
                        cnt_nxt  = CW'(MUL_LAT - 2);
                        nxt      = MUL_WAIT;
                    end else if (lu) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (hz.halt_req || halt_pend) begin
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                        cnt_nxt     = CW'(1);
                        nxt         = DRAIN;
                    end else if (!hz.imem_ready) begin
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
                // release cycle uses plain RUN defaults: EX still shows the finishing MUL
                MUL_WAIT: begin
                    if (cnt != '0) begin
                        pc_we    = 1'b0;
                        if_id_we = 1'b0;
                        ex_hold  = 1'b1;
                        cnt_nxt  = cnt - 1'b1;
                    end else nxt = RUN;
                end
                DRAIN: begin
                    pc_we       = 1'b0;
                    if_id_flush = 1'b1;
                    if (cnt != '0) cnt_nxt = cnt - 1'b1;
                    else nxt = HALT;
                end
                default: begin
                    pc_we       = 1'b0;
                    if_id_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            cnt       <= '0;
            halt_pend <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            halt_pend <= (state == RUN) ? (halt_pend && nxt != DRAIN) : (halt_pend || hz.halt_req);
            halted    <= (nxt == HALT);
            if (!pc_we && state != HALT && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (inc_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.pc_we        = pc_we;
    assign hz.if_id_we     = if_id_we;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.ex_hold      = ex_hold;
    assign hz.halted       = halted;
    assign hz.state_o      = state;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus hand-written multi-cycle sequences
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) hz ();
    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LAT(3), .CNT_W(4)) dut (.clk(clk), .rst(rst), .hz(hz));

    always @(posedge clk)
        if (rst) assert (!(hz.ex_branch_taken && hz.ex_is_mul)) else $error("illegal branch+mul");

    typedef struct {
        logic       br, valid, load, u1, u2, imem;
        logic [4:0] rd, rs1, rs2;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle();
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_rs1_used = 0; hz.id_rs2_used = 0;
        hz.ex_valid = 0; hz.ex_rd = 0; hz.ex_is_load = 0; hz.ex_is_mul = 0;
        hz.ex_branch_taken = 0; hz.imem_ready = 1; hz.halt_req = 0;
    endtask

    task automatic chk_out(input string name, input logic [4:0] exp);
        chk(name, int'({hz.pc_we, hz.if_id_we, hz.if_id_flush, hz.id_ex_bubble, hz.ex_hold}), int'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 0;
        #1 rst = 1;
    endtask

    task automatic mul_in();
        idle();
        hz.ex_valid = 1;
        hz.ex_is_mul = 1;
    endtask

    initial begin
        // outputs packed as {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold}
        tbl[0]  = '{0,0,0,0,0,1, 0,0,0, 5'b11000};
        tbl[1]  = '{0,1,1,1,0,1, 3,3,0, 5'b00010};
        tbl[2]  = '{0,1,1,1,0,1, 0,0,0, 5'b11000};
        tbl[3]  = '{0,1,1,0,1,1, 3,5,3, 5'b00010};
        tbl[4]  = '{0,1,1,0,0,1, 3,5,3, 5'b11000};
        tbl[5]  = '{0,0,1,1,0,1, 3,3,0, 5'b11000};
        tbl[6]  = '{0,1,0,1,0,1, 3,3,0, 5'b11000};
        tbl[7]  = '{1,1,1,1,0,1, 3,3,0, 5'b11110};
        tbl[8]  = '{0,0,0,0,0,0, 0,0,0, 5'b01100};
        tbl[9]  = '{0,1,1,1,0,0, 7,7,0, 5'b00010};
        tbl[10] = '{1,0,0,0,0,0, 0,0,0, 5'b11110};

        idle();
        #1;
        chk_out("reset_outputs", 5'b01110);
        chk("reset_state", int'(hz.state_o), 0);
        chk("reset_stall_cnt", int'(hz.stall_cnt), 0);
        chk("reset_flush_cnt", int'(hz.flush_cnt), 0);
        chk("reset_halted", int'(hz.halted), 0);
        @(negedge clk) rst = 1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle();
            hz.ex_branch_taken = tbl[i].br; hz.ex_valid = tbl[i].valid; hz.ex_is_load = tbl[i].load;
            hz.id_rs1_used = tbl[i].u1; hz.id_rs2_used = tbl[i].u2; hz.imem_ready = tbl[i].imem;
            hz.ex_rd = tbl[i].rd; hz.id_rs1 = tbl[i].rs1; hz.id_rs2 = tbl[i].rs2;
            #1 chk_out($sformatf("vec%0d", i), tbl[i].exp);
        end
        @(negedge clk);
        idle();
        #1;
        chk("table_stall_cnt", int'(hz.stall_cnt), 4);
        chk("table_flush_cnt", int'(hz.flush_cnt), 2);
        chk("table_state", int'(hz.state_o), 0);

        do_reset();
        @(negedge clk); mul_in();
        #1 chk_out("mul_enter", 5'b00001);
        @(negedge clk); #1;
        chk("mul_wait_state", int'(hz.state_o), 1);
        chk_out("mul_wait_hold", 5'b00001);
        @(negedge clk); #1;
        chk("mul_release_state", int'(hz.state_o), 1);
        chk_out("mul_release", 5'b11000);
        @(negedge clk); idle(); #1;
        chk("mul_back_run", int'(hz.state_o), 0);
        chk("mul_stall_cnt", int'(hz.stall_cnt), 2);

        do_reset();
        @(negedge clk); mul_in();
        @(negedge clk); hz.halt_req = 1;
        #1 chk("hm_wait_state", int'(hz.state_o), 1);
        @(negedge clk); hz.halt_req = 0;
        #1 chk_out("hm_release", 5'b11000);
        @(negedge clk); idle(); #1;
        chk("hm_run_state", int'(hz.state_o), 0);
        chk_out("hm_pend_drain", 5'b01100);
        @(negedge clk); #1;
        chk("hm_drain1", int'(hz.state_o), 2);
        chk("hm_drain1_halted", int'(hz.halted), 0);
        chk_out("hm_drain1_out", 5'b01100);
        @(negedge clk); #1;
        chk("hm_drain2", int'(hz.state_o), 2);
        @(negedge clk); #1;
        chk("hm_halt_state", int'(hz.state_o), 3);
        chk("hm_halted", int'(hz.halted), 1);
        chk_out("hm_halt_out", 5'b01100);
        chk("hm_stall_cnt", int'(hz.stall_cnt), 5);
        @(negedge clk); #1;
        chk("hm_halt_stays", int'(hz.state_o), 3);
        chk("hm_halt_no_count", int'(hz.stall_cnt), 5);

        do_reset();
        @(negedge clk); mul_in();
        @(negedge clk); #1;
        chk("rm_wait_state", int'(hz.state_o), 1);
        chk("rm_stall_before", int'(hz.stall_cnt), 1);
        rst = 0;
        idle();
        #1;
        chk("rm_state", int'(hz.state_o), 0);
        chk("rm_stall_cnt", int'(hz.stall_cnt), 0);
        chk_out("rm_forced", 5'b01110);
        rst = 1;
        @(negedge clk); #1;
        chk("rm_run_after", int'(hz.state_o), 0);
        chk_out("rm_run_out", 5'b11000);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            idle();
            hz.imem_ready = 0;
        end
        @(negedge clk); idle(); #1;
        chk("stall_saturate", int'(hz.stall_cnt), 15);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            idle();
            hz.ex_branch_taken = 1;
        end
        @(negedge clk); idle(); #1;
        chk("flush_saturate", int'(hz.flush_cnt), 15);
        chk("stall_held", int'(hz.stall_cnt), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
